// File: rtl/md5_pkg.sv
// md5_pkg: shared widths and the cache-line record used by the digest packer and its line FIFO.
package md5_pkg;
    localparam int HC_DIGEST_WIDTH     = 128;
    localparam int HC_LINE_WIDTH       = 512;
    localparam int HC_DIGESTS_PER_LINE = 4;

    typedef struct packed {
        logic [HC_LINE_WIDTH-1:0] data;
        logic [2:0]               count;
    } t_md5_line;
endpackage

// File: rtl/md5_digest_packer_if.sv
// md5_digest_packer_if: digest input, line output handshake and status bundle.
//   master: requestor/consumer side (drives digests, flush, line_ready)
//   slave : packer side (drives line_out/count/valid and status)
interface md5_digest_packer_if;
    import md5_pkg::*;
    logic [HC_DIGEST_WIDTH-1:0] digest_in;
    logic                       digest_valid;
    logic                       flush;
    logic [HC_LINE_WIDTH-1:0]   line_out;
    logic [2:0]                 line_count;
    logic                       line_valid;
    logic                       line_ready;
    logic                       almost_full;
    logic                       flush_done;
    logic                       overflow_err;
    logic [31:0]                digest_total;

    modport master (
        output digest_in, digest_valid, flush, line_ready,
        input  line_out, line_count, line_valid, almost_full, flush_done, overflow_err, digest_total
    );
    modport slave (
        input  digest_in, digest_valid, flush, line_ready,
        output line_out, line_count, line_valid, almost_full, flush_done, overflow_err, digest_total
    );
endinterface

// File: rtl/md5_line_fifo.sv
// md5_line_fifo: show-ahead FIFO of t_md5_line with occupancy output.
//   clk, reset (async, active-low); push/wr_line write side; pop read side;
//   head is the oldest entry (undefined when empty); occupancy is the entry count.
//   A push while full is ignored unless a pop happens in the same cycle.
module md5_line_fifo
    import md5_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  t_md5_line wr_line,
    input  logic      pop,
    output t_md5_line head,
    output logic [AW:0] occupancy
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          do_pop, wr_en;
    t_md5_line     mem_q [DEPTH];

    always_comb begin
        do_pop   = pop && occ_q != '0;
        wr_en    = push && (occ_q != (AW+1)'(DEPTH) || do_pop);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q + (AW+1)'(wr_en) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: contents are only observed while occupancy > 0.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_line;
    end

    assign head      = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
endmodule

// File: rtl/md5_digest_packer.sv
// md5_digest_packer: packs 128-bit md5 digests into 512-bit lines and buffers them for the c1 write path.
//   clk   : AFU clock
//   reset : asynchronous active-low reset
//   bus   : slave side of md5_digest_packer_if (digests/flush in, lines/status out)
module md5_digest_packer
    import md5_pkg::*;
#(
    parameter int LINE_FIFO_DEPTH = 8,
    parameter int ALMFULL_MARGIN  = 3
) (
    input  logic clk,
    input  logic reset,
    md5_digest_packer_if.slave bus
);
    localparam int AW = $clog2(LINE_FIFO_DEPTH);

    logic [1:0]               idx_q, idx_d;
    logic [HC_LINE_WIDTH-1:0] acc_q, acc_d, merged;
    logic [31:0]              total_q, total_d;
    logic                     flush_done_q, flush_done_d;
    logic                     ovf_q, ovf_d;
    logic                     af_q, af_d;
    logic [2:0]               filled;
    logic                     push, pop, full, wr;
    logic [AW:0]              occ, occ_next;
    t_md5_line                push_line, head;

    always_comb begin
        // Slots above idx are always zero, so OR-ing places the new digest.
        merged       = acc_q | (bus.digest_valid ? (HC_LINE_WIDTH'(bus.digest_in) << {idx_q, 7'd0}) : '0);
        filled       = 3'(idx_q) + 3'(bus.digest_valid);
        push         = (bus.digest_valid && idx_q == 2'(HC_DIGESTS_PER_LINE-1)) || (bus.flush && filled != 3'd0);
        push_line    = '{data: merged, count: filled};
        pop          = occ != '0 && bus.line_ready;
        full         = occ == (AW+1)'(LINE_FIFO_DEPTH);
        wr           = push && (!full || pop);
        occ_next     = occ + (AW+1)'(wr) - (AW+1)'(pop);
        idx_d        = push ? 2'd0 : bus.digest_valid ? idx_q + 2'd1 : idx_q;
        acc_d        = push ? '0 : merged;
        total_d      = total_q + 32'(bus.digest_valid);
        flush_done_d = bus.flush;
        ovf_d        = ovf_q || (push && !wr);
        af_d         = (LINE_FIFO_DEPTH - int'(occ_next)) <= ALMFULL_MARGIN || occ_next == (AW+1)'(LINE_FIFO_DEPTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q        <= '0;
            acc_q        <= '0;
            total_q      <= '0;
            flush_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            af_q         <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            total_q      <= total_d;
            flush_done_q <= flush_done_d;
            ovf_q        <= ovf_d;
            af_q         <= af_d;
        end
    end

    md5_line_fifo #(.DEPTH(LINE_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wr_line   (push_line),
        .pop       (pop),
        .head      (head),
        .occupancy (occ)
    );

    // Mask the unreset FIFO storage so an empty FIFO presents zeros.
    assign bus.line_valid   = occ != '0;
    assign bus.line_out     = bus.line_valid ? head.data : '0;
    assign bus.line_count   = bus.line_valid ? head.count : '0;
    assign bus.almost_full  = af_q;
    assign bus.flush_done   = flush_done_q;
    assign bus.overflow_err = ovf_q;
    assign bus.digest_total = total_q;
endmodule

// File: tb/tb_md5_digest_packer.sv
// tb_md5_digest_packer: randomized scoreboard bench for md5_digest_packer against a queue-based line model.
module tb_md5_digest_packer;
    import md5_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md5_digest_packer_if bus();

    md5_digest_packer #(.LINE_FIFO_DEPTH(8), .ALMFULL_MARGIN(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [127:0] cur[$];
    t_md5_line   expq[$];
    int          occ_m = 0;
    bit          ovf_m = 0;
    logic [31:0] total_m = '0;

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step(bit dv, logic [127:0] d, bit fl, bit rdy);
        bit        pop;
        t_md5_line ln;
        bus.digest_valid = dv;
        bus.digest_in    = d;
        bus.flush        = fl;
        bus.line_ready   = rdy;
        pop = rdy && occ_m > 0;
        if (dv) begin
            cur.push_back(d);
            total_m++;
        end
        if (cur.size() == 4 || (fl && cur.size() > 0)) begin
            ln.data = '0;
            foreach (cur[i]) ln.data[i*128 +: 128] = cur[i];
            ln.count = 3'(cur.size());
            cur.delete();
            if (occ_m < 8 || pop) begin
                expq.push_back(ln);
                occ_m++;
            end else ovf_m = 1;
        end
        if (pop) occ_m--;
        @(posedge clk);
        #1;
        chk("almost_full", bus.almost_full, (8 - occ_m) <= 3);
        chk("overflow_err", bus.overflow_err, ovf_m);
        chk("digest_total", bus.digest_total, total_m);
        chk("flush_done", bus.flush_done, fl);
        chk("line_valid", bus.line_valid, occ_m > 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.digest_valid = 1'b0;
        bus.flush        = 1'b0;
        bus.line_ready   = 1'b0;
        bus.digest_in    = '0;
        #1;
        chk("rst_line_valid", bus.line_valid, 0);
        chk("rst_line_out", bus.line_out, 0);
        chk("rst_line_count", bus.line_count, 0);
        chk("rst_almost_full", bus.almost_full, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_overflow_err", bus.overflow_err, 0);
        chk("rst_digest_total", bus.digest_total, 0);
        cur.delete();
        expq.delete();
        occ_m   = 0;
        ovf_m   = 0;
        total_m = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        t_md5_line e;
        if (rst_n && bus.line_valid && bus.line_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_line got count %0d expected no line", bus.line_count);
            end else begin
                e = expq.pop_front();
                chk("line_out", bus.line_out, e.data);
                chk("line_count", bus.line_count, e.count);
            end
        end
    end

    initial begin
        bus.digest_valid = 1'b0;
        bus.flush        = 1'b0;
        bus.line_ready   = 1'b0;
        bus.digest_in    = '0;
        do_reset();

        for (int i = 1; i <= 4; i++) step(1, 128'(i), 0, 1);
        repeat (2) step(0, '0, 0, 1);

        step(1, rnd128(), 0, 1);
        step(1, rnd128(), 0, 1);
        step(0, '0, 1, 1);
        repeat (2) step(0, '0, 0, 1);
        step(0, '0, 1, 1);
        repeat (2) step(0, '0, 0, 1);

        repeat (3) step(1, rnd128(), 0, 1);
        step(1, rnd128(), 1, 1);
        repeat (3) step(0, '0, 0, 1);

        repeat (35) step(1, rnd128(), 0, 0);
        step(1, rnd128(), 0, 1);
        repeat (10) step(0, '0, 0, 1);

        repeat (40) step(1, rnd128(), 0, 0);
        repeat (12) step(0, '0, 0, 1);

        for (int i = 0; i < 300; i++)
            step($urandom_range(9, 0) < 7, rnd128(), $urandom_range(9, 0) == 0, $urandom_range(1, 0) == 1);
        step(0, '0, 1, 1);
        repeat (12) step(0, '0, 0, 1);

        do_reset();
        step(1, rnd128(), 0, 1);
        step(1, rnd128(), 0, 1);
        do_reset();
        repeat (4) step(1, rnd128(), 0, 1);
        repeat (3) step(0, '0, 0, 1);

        chk("scoreboard_empty", 512'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md5_digest_packer.md
Name: md5_digest_packer

Overview:
- Downstream of the md5 core. Collects the 128-bit digests it emits (valid-only, no backpressure) into 512-bit cache lines.
- Buffers completed lines in a small FIFO for the requestor's c1 write path, which drains them with valid/ready.
- Raises almost_full so the requestor stops issuing new blocks before digests can be lost.

Parameters:
- LINE_FIFO_DEPTH, 8, number of 512-bit lines buffered (power of 2, >= 4).
- ALMFULL_MARGIN, 3, almost_full asserts when free entries <= this value. Covers md5 pipeline in-flight digests.

Ports:
- clk  in  1  CCI-P AFU clock (pClkDiv2 domain).
- reset  in  1  Asynchronous, active-low reset.
- digest_in  in  128  digest from md5 core (data_rx).
- digest_valid  in  1  digest_in valid this cycle (valid_rx). No stall possible.
- flush  in  1  one-cycle pulse: close the current partial line.
- line_out  out  512  FIFO head line.
- line_count  out  3  digests held in line_out (1..4).
- line_valid  out  1  FIFO non-empty.
- line_ready  in  1  consumer accepts the head line when line_valid && line_ready.
- almost_full  out  1  throttle request to the requestor.
- flush_done  out  1  one-cycle pulse when a flush has been fully absorbed.
- overflow_err  out  1  sticky: a completed line was dropped.
- digest_total  out  32  digests accepted since reset (wraps).

Behaviour:
- Design rule: one clock (clk); reset is asynchronous and active-low.
- Reset (reset low):
  - Accumulator, slot index and FIFO are emptied.
  - line_valid=0, line_count=0, line_out=0.
  - almost_full=0, flush_done=0, overflow_err=0, digest_total=0.
- Accumulator:
  - Slot index 0..3. Digest k is written to bits [128k+127:128k]; the index increments on each digest_valid.
  - When slot 3 is written, the line and count=4 are pushed into the FIFO on the same clock edge. The index returns to 0 and the accumulator is cleared to zero.
- Flush:
  - If the index is >0 (or a digest arrives in the same cycle), the partial line is pushed with unused slots zero-filled and count = slots filled, including the same-cycle digest.
  - If the accumulator is empty, nothing is pushed.
  - flush_done pulses in the cycle after the flush.
  - A flush coinciding with a slot-3 digest pushes exactly one line (count=4).
- FIFO:
  - Show-ahead. A push into an empty FIFO gives line_valid=1 in the next cycle: latency from the final digest to line_valid is 1 clk.
  - Pop when line_valid && line_ready. Simultaneous push and pop when full is allowed: occupancy is unchanged and nothing is dropped.
  - Occupancy counter width is log2(DEPTH)+1.
- Overflow:
  - A push with the FIFO full and no pop in the same cycle discards the new line and sets overflow_err.
  - overflow_err clears only on reset. The FIFO contents are untouched.
- almost_full:
  - Registered: (DEPTH - occupancy_next) <= ALMFULL_MARGIN.
  - Also asserted when the FIFO is full.
- digest_total increments on every digest_valid, including digests in dropped lines, and wraps 2^32-1 -> 0.
- line_out and line_count are stable while line_valid=1 and line_ready=0.
- Reset asserted mid-operation discards all data immediately (asynchronous); no partial line is emitted.

Decomposition:
- md5_pkg:
  - constants HC_DIGEST_WIDTH=128, HC_LINE_WIDTH=512, HC_DIGESTS_PER_LINE=4.
  - typedef t_md5_line: struct of the 512-bit data plus the 3-bit count.
- Sub-module md5_line_fifo: generic show-ahead FIFO of t_md5_line with occupancy output, async active-low reset. The packer owns the accumulator, flush and error logic.

Test Plan:
- 4 digests 0x...01..0x...04 on consecutive cycles, line_ready=1 -> one line, slot0=0x..01 ... slot3=0x..04, count=4, line_valid 1 cycle after the 4th digest; digest_total=4.
- 2 digests A,B then flush -> line {0,0,B,A}, count=2; flush_done one cycle later. Flush with an empty accumulator -> no line, flush_done still pulses.
- 3 digests, then digest D plus flush in the same cycle -> single line, count=4, slot3=D; no extra empty line.
- line_ready=0, 40 digests (10 lines), DEPTH=8 -> almost_full asserts when free <= 3 (after 5th line); lines 9 and 10 dropped; overflow_err=1; the 8 buffered lines drain in order; digest_total=40.
- FIFO full, line_ready=1 in the same cycle as a 4th-digest push -> no drop, overflow_err stays 0, occupancy stays 8.
- 2 digests, then reset low mid-line -> all outputs at reset values asynchronously. After release, 4 new digests produce one clean line with count=4.
